// File: rtl/flo_pkg.sv
// rtl/flo_pkg.sv - shared field layout and state encoding for the flo dispatcher
package flo_pkg;

  // Input word field layout
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 16;
  localparam int DELAY_LSB  = 16;
  localparam int DELAY_W    = 7;
  localparam int DIRECT_BIT = 23;
  localparam int CH_LSB     = 24;
  localparam int CH_W       = 4;

  // Stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } state_t;

endpackage

// File: rtl/flo_holdoff.sv
// rtl/flo_holdoff.sv - per-channel saturating write hold-off down-counter
module flo_holdoff #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/flo_dispatch.sv
// rtl/flo_dispatch.sv - one-word staged dispatcher from sequencer stream into N_CH flobuffers
module flo_dispatch
  import flo_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int HOLDOFF   = 1,
  parameter int STALL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DATA_W-1:0]    buf_data_o,
  output logic [DELAY_W-1:0]   buf_delay_o,
  output logic [N_CH-1:0]      buf_valid_o,
  output logic [N_CH-1:0]      buf_direct_o,
  input  logic [N_CH-1:0]      buf_full_i,
  input  logic [N_CH-1:0]      buf_err_i,
  input  logic [N_CH-1:0]      buf_empty_i,
  input  logic                 err_clr_i,
  output logic [N_CH-1:0]      err_o,
  output logic                 bad_ch_o,
  output logic                 stall_err_o,
  output logic                 idle_o
);

  // Wide enough to hold HOLDOFF, never zero width
  localparam int HW = $clog2(HOLDOFF + 2);

  state_t               state, state_nx;
  logic [DATA_W-1:0]    stg_data;
  logic [DELAY_W-1:0]   stg_delay;
  logic                 stg_direct;
  logic [CH_W-1:0]      stg_ch;
  logic [7:0]           stall_cnt;

  logic [N_CH-1:0]      ch_sel;
  logic [N_CH-1:0]      hold_zero;
  logic [N_CH-1:0]      hold_load;
  logic                 pending, ch_bad, ch_ready, issue, stall_drop, free_now, load;

  // Reserved word bits carry nothing for the dispatcher
  wire unused_rsvd = ^in_data_i[31:28];

  assign pending = (state == ST_PEND);

  // Decode the staged channel; an out-of-range channel selects nothing
  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_sel[k] = (stg_ch == CH_W'(k));
    end
  end

  assign ch_bad     = pending && (ch_sel == '0);
  assign ch_ready   = |(ch_sel & ~buf_full_i & hold_zero);
  assign issue      = pending && !ch_bad && (stg_direct || ch_ready);
  assign stall_drop = pending && !ch_bad && !issue && (stall_cnt == 8'(STALL_MAX));
  assign free_now   = issue || ch_bad || stall_drop;
  assign load       = in_valid_i && in_ready_o;
  assign hold_load  = (issue && !stg_direct) ? ch_sel : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nx;
  end

  // Next state: a load always leaves the stage occupied, otherwise freeing empties it
  always_comb begin
    state_nx = state;
    if (load)          state_nx = ST_PEND;
    else if (free_now) state_nx = ST_EMPTY;
  end

  // FSM outputs: accept when the stage is free or is being vacated this cycle
  always_comb begin
    in_ready_o = 1'b0;
    if (!pending || free_now) in_ready_o = 1'b1;
  end

  // Stage capture of the decoded input fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data   <= '0;
      stg_delay  <= '0;
      stg_direct <= 1'b0;
      stg_ch     <= '0;
    end else if (load) begin
      stg_data   <= in_data_i[DATA_LSB +: DATA_W];
      stg_delay  <= in_data_i[DELAY_LSB +: DELAY_W];
      stg_direct <= in_data_i[DIRECT_BIT];
      stg_ch     <= in_data_i[CH_LSB +: CH_W];
    end
  end

  // Stall counter: restarts per word, counts cycles the word sits unissued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (load) begin
      stall_cnt <= '0;
    end else if (pending && !free_now) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // Registered buffer port: strobes last one cycle, data/delay hold until next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_o   <= '0;
      buf_delay_o  <= '0;
      buf_valid_o  <= '0;
      buf_direct_o <= '0;
    end else begin
      buf_valid_o  <= hold_load;
      buf_direct_o <= (issue && stg_direct) ? ch_sel : '0;
      if (issue) begin
        buf_data_o  <= stg_data;
        buf_delay_o <= stg_delay;
      end
    end
  end

  // Sticky error flags: a new set in the clear cycle survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o       <= '0;
      bad_ch_o    <= 1'b0;
      stall_err_o <= 1'b0;
    end else begin
      err_o       <= (err_clr_i ? '0 : err_o) | buf_err_i;
      bad_ch_o    <= (bad_ch_o && !err_clr_i) || ch_bad;
      stall_err_o <= (stall_err_o && !err_clr_i) || stall_drop;
    end
  end

  // Per-channel write hold-off covering the buffer's late full flag
  for (genvar g = 0; g < N_CH; g++) begin : g_hold
    flo_holdoff #(.W(HW)) u_holdoff (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (hold_load[g]),
      .load_val (HW'(HOLDOFF)),
      .zero     (hold_zero[g])
    );
  end

  assign idle_o = !pending && (&hold_zero) && (&buf_empty_i);

endmodule

// File: tb/tb_flo_dispatch.sv
// tb/tb_flo_dispatch.sv - directed self-checking bench for flo_dispatch
module tb_flo_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] buf_data_o;
  logic [6:0]  buf_delay_o;
  logic [3:0]  buf_valid_o, buf_direct_o;
  logic [3:0]  buf_full_i, buf_err_i, buf_empty_i;
  logic        err_clr_i;
  logic [3:0]  err_o;
  logic        bad_ch_o, stall_err_o, idle_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] seen;

  always #5 clk = ~clk;

  flo_dispatch #(.N_CH(4), .HOLDOFF(1), .STALL_MAX(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .buf_data_o   (buf_data_o),
    .buf_delay_o  (buf_delay_o),
    .buf_valid_o  (buf_valid_o),
    .buf_direct_o (buf_direct_o),
    .buf_full_i   (buf_full_i),
    .buf_err_i    (buf_err_i),
    .buf_empty_i  (buf_empty_i),
    .err_clr_i    (err_clr_i),
    .err_o        (err_o),
    .bad_ch_o     (bad_ch_o),
    .stall_err_o  (stall_err_o),
    .idle_o       (idle_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] rsv, input logic [3:0] ch,
                                     input logic dir, input logic [6:0] dly,
                                     input logic [15:0] dat);
    return {rsv, ch, dir, dly, dat};
  endfunction

  initial begin
    rst_n = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
    buf_full_i = '0; buf_err_i = '0; buf_empty_i = 4'hF; err_clr_i = 1'b0;
    tick(); tick();
    check("rst_ready", in_ready_o, 1);
    check("rst_idle", idle_o, 1);
    check("rst_strobes", {buf_valid_o, buf_direct_o}, 0);
    check("rst_bus", {buf_data_o, buf_delay_o}, 0);
    check("rst_errs", {err_o, bad_ch_o, stall_err_o}, 0);
    rst_n = 1'b1;
    tick();

    // single buffered word, reserved bits set and ignored
    in_data_i = mk(4'hA, 4'd2, 1'b0, 7'd5, 16'h1234); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("t1_not_yet", buf_valid_o, 4'b0000);
    check("t1_idle_busy", idle_o, 0);
    tick();
    check("t1_valid", buf_valid_o, 4'b0100);
    check("t1_data", buf_data_o, 16'h1234);
    check("t1_delay", buf_delay_o, 5);
    check("t1_direct", buf_direct_o, 4'b0000);
    tick();
    check("t1_pulse", buf_valid_o, 4'b0000);
    check("t1_data_hold", buf_data_o, 16'h1234);

    // ch0 then ch1 back-to-back
    in_data_i = mk(4'h0, 4'd0, 1'b0, 7'd1, 16'hAAAA); in_valid_i = 1'b1;
    check("t2_ready0", in_ready_o, 1);
    tick();
    in_data_i = mk(4'h0, 4'd1, 1'b0, 7'd2, 16'hBBBB);
    check("t2_ready1", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    check("t2_v0", buf_valid_o, 4'b0001);
    check("t2_d0", buf_data_o, 16'hAAAA);
    tick();
    check("t2_v1", buf_valid_o, 4'b0010);
    check("t2_d1", {buf_data_o, buf_delay_o}, {16'hBBBB, 7'd2});
    tick();

    // same channel back-to-back: hold-off spaces them
    in_data_i = mk(4'h0, 4'd3, 1'b0, 7'd3, 16'h0003); in_valid_i = 1'b1;
    tick();
    in_data_i = mk(4'h0, 4'd3, 1'b0, 7'd4, 16'h0004);
    check("t3_ready_a", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    check("t3_first", buf_valid_o, 4'b1000);
    check("t3_ready_low", in_ready_o, 0);
    tick();
    check("t3_gap", buf_valid_o, 4'b0000);
    check("t3_ready_back", in_ready_o, 1);
    tick();
    check("t3_second", buf_valid_o, 4'b1000);
    check("t3_second_data", buf_data_o, 16'h0004);
    tick(); tick();

    // full channel: word stalls and is dropped
    buf_full_i = 4'b0010;
    in_data_i = mk(4'h0, 4'd1, 1'b0, 7'd9, 16'h5555); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    seen = '0;
    for (int i = 0; i < 254; i++) begin
      seen |= buf_valid_o | buf_direct_o;
      tick();
    end
    check("t4_no_err_yet", stall_err_o, 0);
    check("t4_stalled", in_ready_o, 0);
    seen |= buf_valid_o | buf_direct_o;
    tick();
    seen |= buf_valid_o | buf_direct_o;
    tick();
    seen |= buf_valid_o | buf_direct_o;
    check("t4_stall_err", stall_err_o, 1);
    check("t4_ready", in_ready_o, 1);
    check("t4_no_strobe", seen, 0);
    buf_full_i = '0;
    tick();
    check("t4_no_late_strobe", buf_valid_o, 0);

    // direct write ignores full
    buf_full_i = 4'b0001;
    in_data_i = mk(4'h0, 4'd0, 1'b1, 7'd7, 16'hD00D); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t5_direct", buf_direct_o, 4'b0001);
    check("t5_no_valid", buf_valid_o, 4'b0000);
    check("t5_data", buf_data_o, 16'hD00D);
    buf_full_i = '0;
    tick();

    // out-of-range channel
    in_data_i = mk(4'h0, 4'd9, 1'b0, 7'd1, 16'h9999); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t6_no_strobe", {buf_valid_o, buf_direct_o}, 0);
    check("t6_bad_ch", bad_ch_o, 1);
    check("t6_bus_kept", buf_data_o, 16'hD00D);
    tick();

    // error clear
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t7_bad_clr", bad_ch_o, 0);
    check("t7_stall_clr", stall_err_o, 0);

    // buffer overflow capture
    buf_err_i = 4'b0100;
    tick();
    buf_err_i = '0;
    check("t8_err_set", err_o, 4'b0100);
    tick(); tick();
    check("t8_err_sticky", err_o, 4'b0100);
    err_clr_i = 1'b1; buf_err_i = 4'b0001;
    tick();
    err_clr_i = 1'b0; buf_err_i = '0;
    check("t8_set_wins", err_o, 4'b0001);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t8_err_clr", err_o, 4'b0000);

    // idle tracks buffer emptiness
    check("t9_idle", idle_o, 1);
    buf_empty_i = 4'b1011;
    #1;
    check("t9_not_idle", idle_o, 0);
    buf_empty_i = 4'hF;

    // reset while a word is staged
    buf_full_i = 4'b0010;
    in_data_i = mk(4'h0, 4'd1, 1'b0, 7'd1, 16'h7777); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("t10_staged", in_ready_o, 0);
    rst_n = 1'b0;
    #2;
    check("t10_rst_ready", in_ready_o, 1);
    rst_n = 1'b1;
    buf_full_i = '0;
    tick();
    check("t10_no_strobe", {buf_valid_o, buf_direct_o}, 0);
    tick();
    check("t10_still_none", {buf_valid_o, buf_direct_o}, 0);
    check("t10_idle", idle_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
